// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, byte width
// and a default requester count.
package uart_pkg;

  localparam int BYTE_W    = 8;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_DONE = 2'd2,
    ARB_LOCKED    = 2'd3
  } arb_state_t;

  // Width of a counter that must reach timeout-1; never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first set request bit found
// scanning ptr+1, ptr+2, ... with wrap modulo N_REQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  logic [IDX_W-1:0] cand [N_REQ];
  logic [N_REQ-1:0] hit;

  // cand[gi] is the requester examined at scan offset gi+1 from ptr.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum       = {1'b0, ptr} + (IDX_W+1)'(gi + 1);
      assign cand[gi]  = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                    : sum[IDX_W-1:0];
      assign hit[gi]   = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    grant = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hit[i]) grant = cand[i];
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer between N_REQ byte
// requesters, with per-owner message locking and an idle-lock timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int IDX_W        = 2,
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        done,
  output logic [IDX_W-1:0]        owner,
  output logic                    owner_valid,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  input  logic                    tx_done
);

  localparam int               CNT_W     = cnt_width(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_REQ - 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [CNT_W-1:0]  idle_cnt;
  logic              last_flag;
  logic [IDX_W-1:0]  grant;
  logic              any_req;
  logic [BYTE_W-1:0] req_bytes [N_REQ];

  // Busy is advisory; completion is signalled solely by tx_done.
  logic busy_unused;
  assign busy_unused = tx_busy;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      ptr         <= PTR_RESET;
      idle_cnt    <= '0;
      last_flag   <= 1'b0;
      ack         <= '0;
      done        <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
    end else begin
      ack      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            owner       <= grant;
            tx_data     <= req_bytes[grant];
            last_flag   <= req_last[grant];
            ack[grant]  <= 1'b1;
            owner_valid <= 1'b1;
            tx_start    <= 1'b1;
            state       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          state <= ARB_WAIT_DONE;
        end
        ARB_WAIT_DONE: begin
          if (tx_done) begin
            done[owner] <= 1'b1;
            if (last_flag) begin
              ptr         <= owner;
              owner_valid <= 1'b0;
              state       <= ARB_IDLE;
            end else begin
              idle_cnt <= '0;
              state    <= ARB_LOCKED;
            end
          end
        end
        ARB_LOCKED: begin
          // Only the owner may continue; everyone else waits for release.
          if (req[owner]) begin
            tx_data     <= req_bytes[owner];
            last_flag   <= req_last[owner];
            ack[owner]  <= 1'b1;
            tx_start    <= 1'b1;
            state       <= ARB_ISSUE;
          end else if (idle_cnt == CNT_LAST) begin
            ptr         <= owner;
            owner_valid <= 1'b0;
            state       <= ARB_IDLE;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues drive the
// DUT, a message-level round-robin model predicts the byte order.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int LT = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   ack, done;
  logic [IW-1:0]  owner;
  logic           owner_valid, tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic           tx_done = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .IDX_W(IW), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .done(done), .owner(owner), .owner_valid(owner_valid),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  typedef struct packed { logic [7:0] data; logic last; } byte_t;
  typedef struct packed { logic [IW-1:0] idx; logic [7:0] data; } exp_t;

  byte_t drv_q [N][$];
  exp_t  exp_tx[$], exp_ack[$], exp_done[$];
  int    total = 0, bad = 0, done_seen = 0;
  int    model_ptr = N - 1;
  bit    spurious = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic l);
    byte_t b;
    b.data = d;
    b.last = l;
    drv_q[i].push_back(b);
  endtask

  // Message-level model: the winner sends bytes until one is flagged last or
  // its queue runs dry (lock times out); then the pointer moves to it.
  task automatic build_expected();
    byte_t m [N][$];
    byte_t b;
    exp_t  e;
    int    w;
    for (int i = 0; i < N; i++) m[i] = drv_q[i];
    forever begin
      w = -1;
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (model_ptr + off) % N;
        if (w < 0 && m[c].size() > 0) w = c;
      end
      if (w < 0) break;
      do begin
        b = m[w].pop_front();
        e.idx  = IW'(w);
        e.data = b.data;
        exp_tx.push_back(e);
        exp_ack.push_back(e);
        exp_done.push_back(e);
      end while (!b.last && m[w].size() > 0);
      model_ptr = w;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (drv_q[i].size() != 0) return 1'b0;
    return exp_tx.size() == 0 && exp_ack.size() == 0 && exp_done.size() == 0;
  endfunction

  task automatic wait_idle(input string name);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if (all_empty() && !owner_valid) begin
        check({name, "_owner_valid"}, owner_valid, 0);
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got pending work expected idle", name);
  endtask

  // uart_tx stand-in: random shift time, one-cycle done, aborts on reset.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0; tx_busy = 1'b0; tx_done = 1'b0;
      end else begin
        tx_done = 1'b0;
        if (spurious) begin tx_done = 1'b1; spurious = 1'b0; end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin tx_done = 1'b1; tx_busy = 1'b0; end
        end
        if (tx_start) begin cnt = $urandom_range(1, 6); tx_busy = 1'b1; end
      end
    end
  end

  // Requesters: hold req with the queue head, advance on ack.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() > 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = drv_q[i][0].data;
          req_last[i] = drv_q[i][0].last;
        end else begin
          req[i] = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i] = 1'($urandom);
        end
      end
    end
  end

  // Monitor: compare each start/ack/done pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (exp_tx.size() == 0) check("tx_start_unexpected", 1, 0);
        else begin
          e = exp_tx.pop_front();
          $display("tx owner=%0d data=%02h", owner, tx_data);
          check("tx_data", tx_data, e.data);
          check("tx_owner", owner, e.idx);
          check("tx_owner_valid", owner_valid, 1);
        end
      end
      if (ack != '0) begin
        if (exp_ack.size() == 0) check("ack_unexpected", ack, 0);
        else begin e = exp_ack.pop_front(); check("ack", ack, 32'(1) << e.idx); end
      end
      if (done != '0) begin
        done_seen++;
        if (exp_done.size() == 0) check("done_unexpected", done, 0);
        else begin e = exp_done.pop_front(); check("done", done, 32'(1) << e.idx); end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    bit seen;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    check("rst_owner", owner, 0);
    check("rst_owner_valid", owner_valid, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    rst = 1'b0;

    // Contention: all single-byte messages, order 0,1,2,3,0 from reset.
    load(0, 8'h10, 1); load(0, 8'h15, 1);
    load(1, 8'h11, 1); load(2, 8'h12, 1); load(3, 8'h13, 1);
    build_expected();
    wait_idle("contention");

    // Locked message from requester 1 while 3 waits.
    load(1, 8'h48, 0); load(1, 8'h49, 0); load(1, 8'h0A, 1);
    load(3, 8'h77, 1);
    build_expected();
    wait_idle("locked");

    // Single byte.
    load(2, 8'hA5, 1);
    build_expected();
    wait_idle("single");
    check("single_last_owner", owner, 2);

    // Lock timeout with a spurious tx_done while locked.
    load(0, 8'h21, 0);
    load(2, 8'h22, 1);
    build_expected();
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #2;
      if (done[0]) seen = 1'b1;
    end
    check("timeout_first_done", seen, 1);
    n = 0;
    for (int c = 0; c < 100 && owner_valid; c++) begin
      @(posedge clk); #2;
      n++;
      if (n == 5) spurious = 1'b1;
    end
    check("lock_timeout_cycles", n, LT);
    wait_idle("timeout");

    // Spurious tx_done in IDLE.
    d0 = done_seen;
    spurious = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("idle_spurious_done", done_seen - d0, 0);
    check("idle_spurious_owner_valid", owner_valid, 0);

    // Reset mid-WAIT_DONE.
    load(1, 8'h31, 1);
    build_expected();
    wait_idle("pre_reset");
    load(2, 8'h32, 1);
    build_expected();
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk); #2;
      if (tx_busy) seen = 1'b1;
    end
    check("reset_reached_wait", seen, 1);
    rst = 1'b1;
    @(posedge clk); #2;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_owner", owner, 0);
    check("mid_rst_owner_valid", owner_valid, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) drv_q[i].delete();
    exp_tx.delete(); exp_ack.delete(); exp_done.delete();
    model_ptr = N - 1;
    d0 = done_seen;
    repeat (8) @(posedge clk);
    #2;
    check("post_rst_no_done", done_seen - d0, 0);
    load(0, 8'h40, 1); load(1, 8'h41, 1); load(2, 8'h42, 1); load(3, 8'h43, 1);
    build_expected();
    wait_idle("post_reset");

    // Randomized rounds of messages, some left unterminated.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          int nm;
          nm = $urandom_range(1, 2);
          for (int m = 0; m < nm; m++) begin
            int len;
            bit open;
            len  = $urandom_range(1, 3);
            open = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < len; k++)
              load(i, 8'($urandom), (k == len - 1) && !open);
          end
        end
      end
      build_expected();
      wait_idle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
